// File: rtl/csr_trap_ctrl_if.sv
// csr_trap_ctrl_if: bundles the request, pipeline-CSR, CSR-file and redirect
//   signals of the trap sequencer.
// slave  : sequencer side (csr_trap_ctrl).
// master : environment side (commit stage, pipeline, CSR file, fetch).
interface csr_trap_ctrl_if #(parameter int XLEN = 32);
  // commit-stage requests
  logic            trap_req;
  logic [XLEN-1:0] trap_pc;
  logic [XLEN-1:0] trap_cause;
  logic            mret_req;
  // pipeline CSR traffic
  logic            pipe_csr_we;
  logic [11:0]     pipe_csr_addr_w;
  logic [XLEN-1:0] pipe_csr_wdata;
  logic [11:0]     pipe_csr_addr_r;
  logic [XLEN-1:0] pipe_csr_rdata;
  logic            pipe_stall;
  // CSR file port
  logic            csr_we;
  logic [11:0]     csr_addr_w;
  logic [XLEN-1:0] csr_wdata;
  logic [11:0]     csr_addr_r;
  logic [XLEN-1:0] csr_rdata;
  // fetch redirect / status
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            busy;

  modport slave (
    input  trap_req, trap_pc, trap_cause, mret_req,
    input  pipe_csr_we, pipe_csr_addr_w, pipe_csr_wdata, pipe_csr_addr_r,
    output pipe_csr_rdata, pipe_stall,
    output csr_we, csr_addr_w, csr_wdata, csr_addr_r,
    input  csr_rdata,
    output redirect_valid, redirect_pc, busy
  );

  modport master (
    output trap_req, trap_pc, trap_cause, mret_req,
    output pipe_csr_we, pipe_csr_addr_w, pipe_csr_wdata, pipe_csr_addr_r,
    input  pipe_csr_rdata, pipe_stall,
    input  csr_we, csr_addr_w, csr_wdata, csr_addr_r,
    output csr_rdata,
    input  redirect_valid, redirect_pc, busy
  );
endinterface

// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: trap/mret sequencer owning the machine-mode CSR write port.
// Latency: trap -> mepc/mcause/mstatus writes at +1/+2/+3, redirect at +4;
//   mret -> mstatus write at +1, redirect at +2; idle pass-through is combinational.
// Backpressure: pipe_stall refuses pipeline CSR accesses while a sequence runs.
// Ports: clk, rst (sync, active-high); bus (csr_trap_ctrl_if.slave) carries the
//   requests, pipeline CSR traffic, CSR-file port, redirect and busy.
module csr_trap_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  csr_trap_ctrl_if.slave  bus
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  typedef enum logic [2:0] {
    IDLE, T_MEPC, T_MCAUSE, T_MSTATUS, T_REDIR, R_MSTATUS, R_REDIR
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_cause;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_cause <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.trap_req) begin
            r_pc    <= bus.trap_pc;
            r_cause <= bus.trap_cause;
            r_state <= T_MEPC;
          end else if (bus.mret_req) begin
            r_state <= R_MSTATUS;
          end
        end
        T_MEPC:    r_state <= T_MCAUSE;
        T_MCAUSE:  r_state <= T_MSTATUS;
        T_MSTATUS: r_state <= T_REDIR;
        T_REDIR:   r_state <= IDLE;
        R_MSTATUS: r_state <= R_REDIR;
        R_REDIR:   r_state <= IDLE;
        default:   r_state <= IDLE;
      endcase
    end
  end

  logic            w_we;
  logic [11:0]     w_addr_w;
  logic [XLEN-1:0] w_wdata;
  logic [11:0]     w_addr_r;
  logic            w_redir;
  logic [XLEN-1:0] w_redir_pc;
  logic [XLEN-1:0] w_mst;
  logic            w_busy;
  logic            w_pipe_pend;

  always_comb begin
    w_we       = 1'b0;
    w_addr_w   = '0;
    w_wdata    = '0;
    w_addr_r   = '0;
    w_redir    = 1'b0;
    w_redir_pc = '0;
    w_mst      = bus.csr_rdata;
    case (r_state)
      IDLE: begin
        // A pipe write alongside an accepted request belongs to the flushed
        // instruction, so it is dropped rather than stalled.
        w_we     = bus.pipe_csr_we & ~bus.trap_req & ~bus.mret_req;
        w_addr_w = bus.pipe_csr_addr_w;
        w_wdata  = bus.pipe_csr_wdata;
        w_addr_r = bus.pipe_csr_addr_r;
      end
      T_MEPC: begin
        w_we     = 1'b1;
        w_addr_w = ADDR_MEPC;
        w_wdata  = r_pc;
      end
      T_MCAUSE: begin
        w_we     = 1'b1;
        w_addr_w = ADDR_MCAUSE;
        w_wdata  = r_cause;
      end
      T_MSTATUS: begin
        // MPIE <- MIE, MIE <- 0, MPP <- M
        w_addr_r     = ADDR_MSTATUS;
        w_mst[7]     = bus.csr_rdata[3];
        w_mst[3]     = 1'b0;
        w_mst[12:11] = 2'b11;
        w_we         = 1'b1;
        w_addr_w     = ADDR_MSTATUS;
        w_wdata      = w_mst;
      end
      T_REDIR: begin
        // direct mode only: mtvec mode bits are masked off
        w_addr_r   = ADDR_MTVEC;
        w_redir    = 1'b1;
        w_redir_pc = {bus.csr_rdata[XLEN-1:2], 2'b00};
      end
      R_MSTATUS: begin
        // MIE <- MPIE, MPIE <- 1, MPP <- M
        w_addr_r     = ADDR_MSTATUS;
        w_mst[3]     = bus.csr_rdata[7];
        w_mst[7]     = 1'b1;
        w_mst[12:11] = 2'b11;
        w_we         = 1'b1;
        w_addr_w     = ADDR_MSTATUS;
        w_wdata      = w_mst;
      end
      R_REDIR: begin
        w_addr_r   = ADDR_MEPC;
        w_redir    = 1'b1;
        w_redir_pc = {bus.csr_rdata[XLEN-1:2], 2'b00};
      end
      default: ;
    endcase
  end

  assign w_busy = (r_state != IDLE);
  // No separate read-enable exists; a non-zero read address marks a pending
  // pipeline read.
  assign w_pipe_pend = bus.pipe_csr_we | (bus.pipe_csr_addr_r != 12'h000);

  // Outputs are forced low while reset is held, including the combinational
  // pass-through, so an aborted sequence cannot issue its next write.
  assign bus.csr_we         = ~rst & w_we;
  assign bus.csr_addr_w     = rst ? 12'h000 : w_addr_w;
  assign bus.csr_wdata      = rst ? '0 : w_wdata;
  assign bus.csr_addr_r     = rst ? 12'h000 : w_addr_r;
  assign bus.redirect_valid = ~rst & w_redir;
  assign bus.redirect_pc    = rst ? '0 : w_redir_pc;
  assign bus.busy           = ~rst & w_busy;
  assign bus.pipe_stall     = ~rst & w_busy & w_pipe_pend;
  assign bus.pipe_csr_rdata = bus.csr_rdata;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// tb_csr_trap_ctrl: directed-vector bench for csr_trap_ctrl with a CSR-file model.
// Latency: checks sampled 1 ns after each rising edge.
// Backpressure: pipeline writes held while pipe_stall is high.
module tb_csr_trap_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  csr_trap_ctrl_if #(.XLEN(32)) bus ();

  csr_trap_ctrl #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CSR file model: combinational read, write on posedge; a backdoor port
  // preloads values without going through the DUT.
  logic [31:0] mem [0:4095];
  logic        bd_we;
  logic [11:0] bd_addr;
  logic [31:0] bd_data;

  assign bus.csr_rdata = mem[bus.csr_addr_r];

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (bus.csr_we) mem[bus.csr_addr_w] <= bus.csr_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [11:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    cyc();
    bd_we = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.trap_req = 1'b0; bus.mret_req = 1'b0;
    bus.pipe_csr_we = 1'b0; bus.pipe_csr_addr_w = 12'h000;
    bus.pipe_csr_wdata = 32'h0; bus.pipe_csr_addr_r = 12'h000;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    bd_we = 1'b0; bd_addr = 12'h000; bd_data = 32'h0;
    idle_inputs();
    bus.trap_pc = 32'h0; bus.trap_cause = 32'h0;

    // reset with pipeline traffic active: all outputs must stay 0
    rst = 1'b1;
    bus.pipe_csr_we = 1'b1; bus.pipe_csr_addr_w = 12'h305;
    bus.pipe_csr_wdata = 32'hDEAD; bus.pipe_csr_addr_r = 12'h300;
    cyc(); cyc();
    check("rst_we",     {31'b0, bus.csr_we}, 32'h0);
    check("rst_addr_w", {20'b0, bus.csr_addr_w}, 32'h0);
    check("rst_wdata",  bus.csr_wdata, 32'h0);
    check("rst_busy",   {31'b0, bus.busy}, 32'h0);
    check("rst_stall",  {31'b0, bus.pipe_stall}, 32'h0);
    check("rst_redir",  {31'b0, bus.redirect_valid}, 32'h0);
    idle_inputs();
    rst = 1'b0;
    poke(12'h300, 32'h0000_1808);
    poke(12'h305, 32'h0000_0170);

    // test 1: trap
    bus.trap_req = 1'b1; bus.trap_pc = 32'h100; bus.trap_cause = 32'hB;
    #1;
    check("t1_T_busy", {31'b0, bus.busy}, 32'h0);
    cyc(); bus.trap_req = 1'b0; bus.trap_pc = 32'h0; bus.trap_cause = 32'h0; #1;
    check("t1_T1_we",    {31'b0, bus.csr_we}, 32'h1);
    check("t1_T1_addr",  {20'b0, bus.csr_addr_w}, 32'h341);
    check("t1_T1_data",  bus.csr_wdata, 32'h100);
    check("t1_T1_busy",  {31'b0, bus.busy}, 32'h1);
    cyc();
    check("t1_T2_addr",  {20'b0, bus.csr_addr_w}, 32'h342);
    check("t1_T2_data",  bus.csr_wdata, 32'hB);
    cyc();
    check("t1_T3_addr",  {20'b0, bus.csr_addr_w}, 32'h300);
    check("t1_T3_data",  bus.csr_wdata, 32'h1880);
    cyc();
    check("t1_T4_redir", {31'b0, bus.redirect_valid}, 32'h1);
    check("t1_T4_pc",    bus.redirect_pc, 32'h170);
    check("t1_T4_we",    {31'b0, bus.csr_we}, 32'h0);
    cyc();
    check("t1_T5_busy",  {31'b0, bus.busy}, 32'h0);
    check("t1_T5_redir", {31'b0, bus.redirect_valid}, 32'h0);
    check("t1_mepc",     mem[12'h341], 32'h100);

    // test 2: mret (mstatus already 0x1880)
    poke(12'h341, 32'h104);
    bus.mret_req = 1'b1;
    cyc(); bus.mret_req = 1'b0; #1;
    check("t2_T1_addr",  {20'b0, bus.csr_addr_w}, 32'h300);
    check("t2_T1_data",  bus.csr_wdata, 32'h1888);
    cyc();
    check("t2_T2_redir", {31'b0, bus.redirect_valid}, 32'h1);
    check("t2_T2_pc",    bus.redirect_pc, 32'h104);
    cyc();
    check("t2_T3_busy",  {31'b0, bus.busy}, 32'h0);

    // test 3: pipeline write in IDLE, then trap uses the new mtvec
    bus.pipe_csr_we = 1'b1; bus.pipe_csr_addr_w = 12'h305; bus.pipe_csr_wdata = 32'h200;
    #1;
    check("t3_we",    {31'b0, bus.csr_we}, 32'h1);
    check("t3_addr",  {20'b0, bus.csr_addr_w}, 32'h305);
    check("t3_stall", {31'b0, bus.pipe_stall}, 32'h0);
    cyc(); idle_inputs();
    bus.trap_req = 1'b1; bus.trap_pc = 32'h200; bus.trap_cause = 32'h2;
    cyc(); bus.trap_req = 1'b0; #1;
    cyc(); cyc(); cyc();
    check("t3_redir", {31'b0, bus.redirect_valid}, 32'h1);
    check("t3_pc",    bus.redirect_pc, 32'h200);
    cyc();

    // test 4: pipe write stalled during a trap, lands after IDLE
    bus.trap_req = 1'b1; bus.trap_pc = 32'h300; bus.trap_cause = 32'h4;
    cyc(); bus.trap_req = 1'b0; #1;
    cyc();
    bus.pipe_csr_we = 1'b1; bus.pipe_csr_addr_w = 12'h340; bus.pipe_csr_wdata = 32'hABCD;
    #1;
    check("t4_T2_stall", {31'b0, bus.pipe_stall}, 32'h1);
    check("t4_T2_addr",  {20'b0, bus.csr_addr_w}, 32'h342);
    cyc();
    check("t4_T3_stall", {31'b0, bus.pipe_stall}, 32'h1);
    check("t4_T3_addr",  {20'b0, bus.csr_addr_w}, 32'h300);
    cyc();
    check("t4_T4_stall", {31'b0, bus.pipe_stall}, 32'h1);
    check("t4_T4_we",    {31'b0, bus.csr_we}, 32'h0);
    cyc();
    check("t4_T5_stall", {31'b0, bus.pipe_stall}, 32'h0);
    check("t4_T5_we",    {31'b0, bus.csr_we}, 32'h1);
    check("t4_T5_addr",  {20'b0, bus.csr_addr_w}, 32'h340);
    cyc(); idle_inputs();
    check("t4_landed",   mem[12'h340], 32'hABCD);

    // test 5: trap, mret and pipe write together: trap wins, pipe dropped
    bus.trap_req = 1'b1; bus.mret_req = 1'b1; bus.trap_pc = 32'h400; bus.trap_cause = 32'h3;
    bus.pipe_csr_we = 1'b1; bus.pipe_csr_addr_w = 12'h7C0; bus.pipe_csr_wdata = 32'h55;
    #1;
    check("t5_T_we",    {31'b0, bus.csr_we}, 32'h0);
    check("t5_T_stall", {31'b0, bus.pipe_stall}, 32'h0);
    cyc(); idle_inputs(); #1;
    check("t5_T1_addr", {20'b0, bus.csr_addr_w}, 32'h341);
    cyc();
    check("t5_T2_addr", {20'b0, bus.csr_addr_w}, 32'h342);
    cyc(); cyc();
    check("t5_T4_pc",   bus.redirect_pc, 32'h200);
    cyc();
    check("t5_dropped", mem[12'h7C0], 32'h0);
    check("t5_mcause",  mem[12'h342], 32'h3);

    // test 6: reset at T+2 aborts the sequence
    poke(12'h300, 32'h0000_0008);
    bus.trap_req = 1'b1; bus.trap_pc = 32'h500; bus.trap_cause = 32'h7;
    cyc(); bus.trap_req = 1'b0; #1;
    cyc();
    rst = 1'b1; #1;
    check("t6_rst_we",    {31'b0, bus.csr_we}, 32'h0);
    check("t6_rst_redir", {31'b0, bus.redirect_valid}, 32'h0);
    cyc(); rst = 1'b0; #1;
    for (int k = 0; k < 4; k++) begin
      check("t6_no_redir", {31'b0, bus.redirect_valid}, 32'h0);
      check("t6_busy",     {31'b0, bus.busy}, 32'h0);
      cyc();
    end
    check("t6_mepc",    mem[12'h341], 32'h500);
    check("t6_mcause",  mem[12'h342], 32'h3);
    check("t6_mstatus", mem[12'h300], 32'h0000_0008);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
